// File: rtl/rv32i_types.sv
// Shared result-bus types and defaults used by the FU wrappers, the CDB arbiter and the ROB.
package rv32i_types;

  localparam int unsigned NUM_FU_DEF = 3;
  localparam int unsigned QDEPTH_DEF = 2;
  localparam int unsigned TAG_W_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 32;

  // Broadcast as seen by reservation stations and the ROB.
  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] value;
  } cdb_t;

  // One buffered result waiting for the bus.
  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] value;
  } cdb_entry_t;

  // Increment an index in the range [0, n-1], wrapping n-1 back to 0.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    if ((idx + 32'd1) >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = idx + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Single-unit circular result queue: enqueue at tail, dequeue at head, flush empties it.
// No bypass: an entry written this cycle becomes visible at head on the next cycle.
module cdb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  // Pointer advance with explicit wrap from DEPTH-1 to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) begin
      n = PTR_W'(0);
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == CNT_W'(0));
  assign head  = mem_r[head_r];

  // Qualify requests: nothing moves during reset or flush, and full/empty guard the ends.
  always_comb begin
    push_s = enq && !full && !flush && !rst;
    pop_s  = deq && !empty && !flush && !rst;
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[tail_r] <= enq_data;
    end
  end

  // Head, tail and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_r  <= PTR_W'(0);
      tail_r  <= PTR_W'(0);
      count_r <= CNT_W'(0);
    end else begin
      if (push_s) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from each functional unit in its own queue
// and broadcasts one result per cycle, round-robin across units, from a registered output.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_FU = NUM_FU_DEF,
  parameter int unsigned QDEPTH = QDEPTH_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_value,
  output logic [NUM_FU-1:0]              fu_ready,
  input  logic                           flush,
  output logic                           cdb_valid,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [DATA_W-1:0]              cdb_value,
  output logic [$clog2(NUM_FU)-1:0]      cdb_src
);

  localparam int unsigned SRC_W   = $clog2(NUM_FU);
  localparam int unsigned ENTRY_W = TAG_W + DATA_W;

  logic [NUM_FU-1:0]  full_s;
  logic [NUM_FU-1:0]  empty_s;
  logic [NUM_FU-1:0]  enq_s;
  logic [NUM_FU-1:0]  deq_s;
  logic [ENTRY_W-1:0] head_s [NUM_FU];
  logic [ENTRY_W-1:0] sel_entry_s;
  logic               grant_valid_s;
  logic [SRC_W-1:0]   grant_idx_s;
  logic [SRC_W-1:0]   rr_next_s;
  logic [SRC_W-1:0]   rr_r;

  // One queue per functional unit; tag sits above value in each stored entry.
  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    cdb_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .enq      (enq_s[g]),
      .enq_data ({fu_tag[g], fu_value[g]}),
      .deq      (deq_s[g]),
      .head     (head_s[g]),
      .full     (full_s[g]),
      .empty    (empty_s[g])
    );
  end

  // Ready reflects queue occupancy only, so a full queue stays not-ready even while draining.
  always_comb begin
    if (rst) begin
      fu_ready = '0;
    end else begin
      fu_ready = ~full_s;
    end
  end

  assign enq_s = fu_valid & fu_ready;

  // Round-robin search: first nonempty queue at or above the pointer, then wrap to the low indices.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (!grant_valid_s && !empty_s[i] && (SRC_W'(i) >= rr_r)) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = SRC_W'(i);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (!grant_valid_s && !empty_s[i] && (SRC_W'(i) < rr_r)) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = SRC_W'(i);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Dequeue strobe and head-of-queue selection for the granted unit.
  always_comb begin
    deq_s       = '0;
    sel_entry_s = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant_valid_s && (grant_idx_s == SRC_W'(i))) begin
        deq_s[i]    = 1'b1;
        sel_entry_s = head_s[i];
      end else begin
        deq_s[i] = 1'b0;
      end
    end
  end

  assign rr_next_s = SRC_W'(rr_wrap_inc(32'(grant_idx_s), NUM_FU));

  // Round-robin pointer: moves past the granted unit, holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_r <= '0;
    end else if (grant_valid_s) begin
      rr_r <= rr_next_s;
    end else begin
      rr_r <= rr_r;
    end
  end

  // Registered broadcast; all fields read zero whenever the bus is idle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
    end else if (grant_valid_s) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= sel_entry_s[ENTRY_W-1:DATA_W];
      cdb_value <= sel_entry_s[DATA_W-1:0];
      cdb_src   <= grant_idx_s;
    end else begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
    end
  end

endmodule
